// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// parity-mode constants also used by the transmitter.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int CNT_W     = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // Parity mode: PAR_ODD means the parity bit is ~^data.
  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_mode_t;

  function automatic logic parity_error(input logic [DATA_BITS-1:0] data,
                                        input logic                 pbit,
                                        input logic                 odd);
    return (^{data, pbit}) != odd;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side result bundle: the received byte, its status flags and the
// update strobe, plus the receiver busy indication.
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output rx_data,
    output rx_valid,
    output parity_err,
    output frame_err,
    output busy
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input parity_err,
    input frame_err,
    input busy
  );

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle (high) level so reset release never looks like a start bit.
module uart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= 1'b1;
      sync_out <= 1'b1;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, one parity bit, first stop bit checked.
// Bit timing comes from an external baud generator enabled by bps_en.
module uart_rx
  import uart_pkg::*;
#(
  parameter bit PARITY_ODD = PAR_ODD
) (
  input  logic      clk,
  input  logic      rst_n,
  output logic      bps_en,
  input  logic      bps_clk,
  input  logic      rs422_rx,
  uart_rx_if.master rx
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  logic                 line_sync;
  logic                 line_hist;
  logic                 start_cond;
  rx_state_t            state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_err_q;

  uart_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (rs422_rx),
    .sync_out (line_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) line_hist <= 1'b1;
    else        line_hist <= line_sync;
  end

  // Falling edge only: a line held low after a framing error never restarts.
  assign start_cond = line_hist & ~line_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      bps_en        <= 1'b0;
      bit_cnt       <= '0;
      shift         <= '0;
      par_err_q     <= 1'b0;
      rx.rx_data    <= '0;
      rx.rx_valid   <= 1'b0;
      rx.parity_err <= 1'b0;
      rx.frame_err  <= 1'b0;
      rx.busy       <= 1'b0;
    end else begin
      rx.rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_cond) begin
            state   <= ST_START;
            bps_en  <= 1'b1;
            rx.busy <= 1'b1;
          end
        end

        ST_START: begin
          if (bps_clk) begin
            if (!line_sync) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end else begin
              state   <= ST_IDLE;
              bps_en  <= 1'b0;
              rx.busy <= 1'b0;
            end
          end
        end

        ST_DATA: begin
          if (bps_clk) begin
            shift <= {line_sync, shift[DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) begin
              state   <= ST_PARITY;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        ST_PARITY: begin
          if (bps_clk) begin
            par_err_q <= parity_error(shift, line_sync, PARITY_ODD);
            state     <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (bps_clk) begin
            rx.rx_data    <= shift;
            rx.parity_err <= par_err_q;
            rx.frame_err  <= ~line_sync;
            rx.rx_valid   <= 1'b1;
            bps_en        <= 1'b0;
            rx.busy       <= 1'b0;
            state         <= ST_IDLE;
          end
        end

        default: begin
          state   <= ST_IDLE;
          bps_en  <= 1'b0;
          rx.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
